obi_multi_port_ram: RTL and testbench

- Parametrised successor of the two-port testbench OBI memory.
- One shared word array is served by NUM_PORTS independent OBI slave ports, each fully pipelined: one request per cycle per port.
- Read/write response latency is configurable.
- Used in tb as instruction/data/DMA backing store for multi-core GPGPU simulations.

---
 rtl/obi_multi_port_ram.sv | 75 +++++++
 tb/tb_obi_multi_port_ram.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/obi_multi_port_ram.sv
`default_nettype none
// ============================================================================
// Module   : obi_multi_port_ram
// Brief    : Shared word memory behind NUM_PORTS pipelined OBI slave ports.
//            Behavioural model for simulation backing store.
// Revision : 1.0 - initial release
// ============================================================================
module obi_multi_port_ram #(
    parameter int MEM_SIZE_WORD = 32768,
    parameter int NUM_PORTS     = 2,
    parameter int RSP_LATENCY   = 1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [NUM_PORTS-1:0]    req_i,
    input  logic [NUM_PORTS-1:0]    we_i,
    input  logic [4*NUM_PORTS-1:0]  be_i,
    input  logic [32*NUM_PORTS-1:0] addr_i,
    input  logic [32*NUM_PORTS-1:0] wdata_i,
    output logic [NUM_PORTS-1:0]    gnt_o,
    output logic [NUM_PORTS-1:0]    rvalid_o,
    output logic [32*NUM_PORTS-1:0] rdata_o
);

    localparam int c_AW = $clog2(MEM_SIZE_WORD);

    logic [31:0]     r_mem [MEM_SIZE_WORD];
    logic [c_AW-1:0] w_idx [NUM_PORTS];
    logic            w_unused_addr;

    // Byte-offset and high address bits are don't-care (addresses wrap).
    assign w_unused_addr = ^addr_i;

    assign gnt_o = req_i;

    // Ports are visited highest first so the lowest-index port's lane write lands last and wins.
    always_ff @(posedge clk_i) begin
        for (int p = NUM_PORTS - 1; p >= 0; p--) begin
            for (int b = 0; b < 4; b++) begin
                if (req_i[p] && we_i[p] && be_i[4*p+b]) begin
                    r_mem[w_idx[p]][8*b +: 8] <= wdata_i[32*p+8*b +: 8];
                end
            end
        end
    end

    for (genvar gp = 0; gp < NUM_PORTS; gp++) begin : g_port
        logic [RSP_LATENCY-1:0]       r_valid;
        logic [RSP_LATENCY-1:0][31:0] r_data;
        logic [31:0]                  w_rd;

        assign w_idx[gp] = addr_i[32*gp+2 +: c_AW];
        // Writes and idle slots carry zero data so rdata stays 0 outside read responses.
        assign w_rd = (req_i[gp] && !we_i[gp]) ? r_mem[w_idx[gp]] : 32'h0;

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                r_valid <= '0;
                r_data  <= '0;
            end else begin
                r_valid[0] <= req_i[gp];
                r_data[0]  <= w_rd;
                for (int s = 1; s < RSP_LATENCY; s++) begin
                    r_valid[s] <= r_valid[s-1];
                    r_data[s]  <= r_data[s-1];
                end
            end
        end

        assign rvalid_o[gp]         = r_valid[RSP_LATENCY-1];
        assign rdata_o[32*gp +: 32] = r_data[RSP_LATENCY-1];
    end

endmodule
`default_nettype wire

// File: tb/tb_obi_multi_port_ram.sv
`default_nettype none
// ============================================================================
// Module   : tb_obi_multi_port_ram
// Brief    : Scoreboard bench for obi_multi_port_ram with a word-array model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_obi_multi_port_ram;

    localparam int MEM = 1024;
    localparam int NP  = 3;
    localparam int LAT = 3;

    typedef struct {
        int unsigned due;
        logic [31:0] data;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NP-1:0]   req = '0, we = '0, gnt, rvalid;
    logic [4*NP-1:0] be = '0;
    logic [32*NP-1:0] addr = '0, wdata = '0, rdata;

    logic [NP-1:0]    n_req = '0, n_we = '0;
    logic [4*NP-1:0]  n_be = '0;
    logic [32*NP-1:0] n_addr = '0, n_wdata = '0;

    logic [31:0] ref_mem [MEM];
    exp_t        q [NP][$];
    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    obi_multi_port_ram #(
        .MEM_SIZE_WORD(MEM),
        .NUM_PORTS    (NP),
        .RSP_LATENCY  (LAT)
    ) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .req_i   (req),
        .we_i    (we),
        .be_i    (be),
        .addr_i  (addr),
        .wdata_i (wdata),
        .gnt_o   (gnt),
        .rvalid_o(rvalid),
        .rdata_o (rdata)
    );

    task automatic set_port(input int p, input logic w, input logic [3:0] b,
                            input logic [31:0] a, input logic [31:0] d);
        n_req[p]            = 1'b1;
        n_we[p]             = w;
        n_be[4*p +: 4]      = b;
        n_addr[32*p +: 32]  = a;
        n_wdata[32*p +: 32] = d;
    endtask

    // Present one cycle of requests and update the reference memory for it.
    task automatic step();
        int unsigned idx;
        logic [31:0] a, d;
        exp_t e;
        @(negedge clk);
        #1;
        req = n_req; we = n_we; be = n_be; addr = n_addr; wdata = n_wdata;
        for (int p = 0; p < NP; p++) begin
            if (n_req[p]) begin
                a      = n_addr[32*p +: 32];
                idx    = (a / 4) % MEM;
                e.due  = cyc + LAT;
                e.data = n_we[p] ? 32'h0 : ref_mem[idx];
                q[p].push_back(e);
            end
        end
        for (int p = NP - 1; p >= 0; p--) begin
            if (n_req[p] && n_we[p]) begin
                a   = n_addr[32*p +: 32];
                d   = n_wdata[32*p +: 32];
                idx = (a / 4) % MEM;
                for (int b = 0; b < 4; b++)
                    if (n_be[4*p+b]) ref_mem[idx][8*b +: 8] = d[8*b +: 8];
            end
        end
        n_req = '0; n_we = '0; n_be = '0; n_addr = '0; n_wdata = '0;
        #1;
        checks++;
        if (gnt !== req) begin
            errors++;
            $display("FAIL grant got=%b expected=%b", gnt, req);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        for (int p = 0; p < NP; p++) begin
            if (rvalid[p]) begin
                checks++;
                if (q[p].size() == 0) begin
                    errors++;
                    $display("FAIL spurious_rvalid port=%0d cyc=%0d got rdata=%h expected no response",
                             p, cyc, rdata[32*p +: 32]);
                end else begin
                    e = q[p].pop_front();
                    if (e.due != cyc || rdata[32*p +: 32] !== e.data) begin
                        errors++;
                        $display("FAIL response port=%0d got cyc=%0d rdata=%h expected cyc=%0d rdata=%h",
                                 p, cyc, rdata[32*p +: 32], e.due, e.data);
                    end
                end
            end else begin
                checks++;
                if (rdata[32*p +: 32] !== 32'h0) begin
                    errors++;
                    $display("FAIL rdata_idle port=%0d got=%h expected=0", p, rdata[32*p +: 32]);
                end
                if (q[p].size() > 0 && q[p][0].due <= cyc) begin
                    e = q[p].pop_front();
                    errors++;
                    $display("FAIL missing_rvalid port=%0d got none at cyc=%0d expected rdata=%h at cyc=%0d",
                             p, cyc, e.data, e.due);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        checks++;
        if (rvalid !== '0 || rdata !== '0) begin
            errors++;
            $display("FAIL reset_state got rvalid=%b rdata=%h expected all zero", rvalid, rdata);
        end
        #1 rst = 1'b0;

        // Preload words 0..31 with i*3, spreading writes over all ports.
        for (int i = 0; i < 32; i++) begin
            set_port(i % NP, 1'b1, 4'hF, 32'(i * 4), 32'(i * 3));
            step();
        end

        // Back-to-back reads on port 0.
        for (int i = 0; i < 8; i++) begin
            set_port(0, 1'b0, 4'h0, 32'(i * 4), 32'h0);
            step();
        end

        // Partial byte-enable write, then read back.
        set_port(1, 1'b1, 4'hF, 32'h10, 32'h11223344); step();
        set_port(0, 1'b1, 4'b0101, 32'h10, 32'hAABBCCDD); step();
        set_port(2, 1'b0, 4'h0, 32'h10, 32'h0); step();
        set_port(0, 1'b1, 4'h0, 32'h14, 32'hFFFFFFFF); step();
        set_port(1, 1'b0, 4'h0, 32'h14, 32'h0); step();

        // Full write on port 0, read on port 1.
        set_port(0, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF); step();
        set_port(1, 1'b0, 4'h0, 32'h10, 32'h0); step();

        // Same-word collision with a concurrent read.
        set_port(0, 1'b1, 4'hF, 32'h8, 32'h0); step();
        set_port(0, 1'b1, 4'b0001, 32'h8, 32'h000000AA);
        set_port(1, 1'b1, 4'b0011, 32'h8, 32'h0000BBCC);
        set_port(2, 1'b0, 4'h0, 32'h8, 32'h0);
        step();
        set_port(0, 1'b0, 4'h0, 32'h8, 32'h0); step();

        // Address wrap: word 1025 aliases word 1.
        set_port(2, 1'b1, 4'hF, 32'h0000_1004, 32'h5A5A5A5A); step();
        set_port(0, 1'b0, 4'h0, 32'h4, 32'h0); step();
        repeat (LAT + 1) step();

        // Reset with three reads in flight on port 0.
        for (int i = 0; i < 3; i++) begin
            set_port(0, 1'b0, 4'h0, 32'(i * 4), 32'h0);
            step();
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        req = '0;
        #1;
        checks++;
        if (rvalid !== '0 || rdata !== '0) begin
            errors++;
            $display("FAIL reset_flush got rvalid=%b rdata=%h expected all zero", rvalid, rdata);
        end
        for (int p = 0; p < NP; p++) q[p].delete();
        @(negedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (rvalid !== '0) begin
                errors++;
                $display("FAIL post_reset_rvalid got=%b expected=0", rvalid);
            end
        end
        set_port(1, 1'b0, 4'h0, 32'h14, 32'h0); step();

        // Random traffic on a small window to provoke collisions and wraps.
        for (int i = 0; i < 300; i++) begin
            for (int p = 0; p < NP; p++) begin
                if ($urandom_range(3) != 0)
                    set_port(p, 1'($urandom_range(1)), 4'($urandom_range(15)),
                             ($urandom & 32'hFFFF_F000) | 32'($urandom_range(31) * 4)
                             | 32'($urandom_range(3)), $urandom);
            end
            step();
        end

        repeat (LAT + 3) step();
        for (int p = 0; p < NP; p++) begin
            checks++;
            if (q[p].size() != 0) begin
                errors++;
                $display("FAIL drain port=%0d got %0d outstanding expected 0", p, q[p].size());
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
